// File: rtl/vend_controller.sv
// Vend sequencer: accumulates coin credit, validates selections against a price table,
// drives the dispenser and returns change. Optional per-slot stock tracking via VEND_STOCK_EN.
module vend_controller #(
  parameter int N_SLOTS      = 8,
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 200,
  parameter logic [N_SLOTS*CREDIT_W-1:0] PRICES = {N_SLOTS{8'd50}},
  parameter int DISP_TIMEOUT = 255,
`ifdef VEND_STOCK_EN
  parameter logic [N_SLOTS*8-1:0] STOCK_INIT = {N_SLOTS{8'd10}},
`endif
  localparam int SEL_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  input  logic                disp_done,
  output logic                dispense_req,
  output logic                payment_ok,
  output logic [SEL_W-1:0]    slot,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                fault,
`ifdef VEND_STOCK_EN
  output logic [N_SLOTS-1:0]  sold_out,
`endif
  output logic                busy
);

  localparam int CNT_W = $clog2(DISP_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CREDIT, ST_VEND, ST_CHANGE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [CREDIT_W-1:0] r_price, w_price_nxt;
  logic [SEL_W-1:0]    r_slot, w_slot_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_fault, w_fault_nxt;
  logic                r_coin_reject, w_coin_reject_nxt;
  logic                r_sel_reject, w_sel_reject_nxt;
  logic                r_change_valid, w_change_valid_nxt;
  logic [CREDIT_W-1:0] r_change_amount, w_change_amount_nxt;
  logic                r_dispense_req, r_payment_ok, r_busy;
  logic                w_stock_dec;
  logic                w_sel_take;

  logic [CREDIT_W-1:0] w_sel_price;
  logic                w_sel_in_range;
  logic                w_sel_stock;
  logic                w_sel_ok;

  // Coin acceptance is judged one bit wider so an overflowing sum cannot wrap under the ceiling.
  function automatic logic coin_fits(input logic [CREDIT_W-1:0] cur, input logic [CREDIT_W-1:0] add);
    logic [CREDIT_W:0] sum;
    sum = {1'b0, cur} + {1'b0, add};
    return sum <= (CREDIT_W+1)'(MAX_CREDIT);
  endfunction

  function automatic logic [CREDIT_W-1:0] credit_add(input logic [CREDIT_W-1:0] cur,
                                                     input logic [CREDIT_W-1:0] add);
    return cur + add;
  endfunction

`ifdef VEND_STOCK_EN
  logic [7:0]         r_stock [N_SLOTS];
  logic [N_SLOTS-1:0] w_sold_out;

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_SLOTS; k++) begin
      if (rst)
        r_stock[k] <= STOCK_INIT[k*8 +: 8];
      else if (w_stock_dec && (r_slot == SEL_W'(k)) && (r_stock[k] != 8'd0))
        r_stock[k] <= r_stock[k] - 8'd1;
    end
  end

  always_comb begin
    w_sold_out = '0;
    for (int k = 0; k < N_SLOTS; k++)
      w_sold_out[k] = (r_stock[k] == 8'd0);
  end

  assign sold_out = w_sold_out;
`endif

  // Slot lookup: out-of-range ids never match, so they are refused without a compare against N_SLOTS.
  always_comb begin
    w_sel_price    = '0;
    w_sel_in_range = 1'b0;
    w_sel_stock    = 1'b1;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (sel_id == SEL_W'(k)) begin
        w_sel_in_range = 1'b1;
        w_sel_price    = PRICES[k*CREDIT_W +: CREDIT_W];
`ifdef VEND_STOCK_EN
        w_sel_stock    = (r_stock[k] != 8'd0);
`endif
      end
    end
  end

  assign w_sel_ok = w_sel_in_range && (r_credit >= w_sel_price) && w_sel_stock;

  always_comb begin
    w_state_nxt         = r_state;
    w_credit_nxt        = r_credit;
    w_price_nxt         = r_price;
    w_slot_nxt          = r_slot;
    w_cnt_nxt           = r_cnt;
    w_fault_nxt         = r_fault;
    w_coin_reject_nxt   = 1'b0;
    w_sel_reject_nxt    = 1'b0;
    w_change_valid_nxt  = 1'b0;
    w_change_amount_nxt = r_change_amount;
    w_stock_dec         = 1'b0;
    w_sel_take          = 1'b0;

    case (r_state)
      ST_IDLE, ST_CREDIT: begin
        if (cancel && (r_state == ST_CREDIT)) begin
          w_change_valid_nxt  = 1'b1;
          w_change_amount_nxt = r_credit;
          w_credit_nxt        = '0;
          w_state_nxt         = ST_IDLE;
          w_coin_reject_nxt   = coin_valid;
        end else begin
          if (sel_valid) begin
            if ((r_state == ST_CREDIT) && w_sel_ok) begin
              w_sel_take  = 1'b1;
              w_state_nxt = ST_VEND;
              w_slot_nxt  = sel_id;
              w_price_nxt = w_sel_price;
              w_cnt_nxt   = '0;
            end else begin
              w_sel_reject_nxt = 1'b1;
            end
          end
          if (coin_valid) begin
            if (!w_sel_take && coin_fits(r_credit, coin_value)) begin
              w_credit_nxt = credit_add(r_credit, coin_value);
              w_state_nxt  = ST_CREDIT;
              w_fault_nxt  = 1'b0;
            end else begin
              w_coin_reject_nxt = 1'b1;
            end
          end
        end
      end
      ST_VEND: begin
        w_coin_reject_nxt = coin_valid;
        if (disp_done) begin
          w_credit_nxt = r_credit - r_price;
          w_state_nxt  = ST_CHANGE;
          w_cnt_nxt    = '0;
          w_stock_dec  = 1'b1;
        end else if (r_cnt == CNT_W'(DISP_TIMEOUT - 1)) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = ST_CHANGE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_CHANGE: begin
        w_coin_reject_nxt = coin_valid;
        if (r_credit != '0) begin
          w_change_valid_nxt  = 1'b1;
          w_change_amount_nxt = r_credit;
        end
        w_credit_nxt = '0;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_credit        <= '0;
      r_price         <= '0;
      r_slot          <= '0;
      r_cnt           <= '0;
      r_fault         <= 1'b0;
      r_coin_reject   <= 1'b0;
      r_sel_reject    <= 1'b0;
      r_change_valid  <= 1'b0;
      r_change_amount <= '0;
      r_dispense_req  <= 1'b0;
      r_payment_ok    <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_credit        <= w_credit_nxt;
      r_price         <= w_price_nxt;
      r_slot          <= w_slot_nxt;
      r_cnt           <= w_cnt_nxt;
      r_fault         <= w_fault_nxt;
      r_coin_reject   <= w_coin_reject_nxt;
      r_sel_reject    <= w_sel_reject_nxt;
      r_change_valid  <= w_change_valid_nxt;
      r_change_amount <= w_change_amount_nxt;
      r_dispense_req  <= (w_state_nxt == ST_VEND);
      r_payment_ok    <= (w_state_nxt == ST_VEND);
      r_busy          <= (w_state_nxt == ST_VEND) || (w_state_nxt == ST_CHANGE);
    end
  end

  assign dispense_req  = r_dispense_req;
  assign payment_ok    = r_payment_ok;
  assign slot          = r_slot;
  assign credit        = r_credit;
  assign coin_reject   = r_coin_reject;
  assign sel_reject    = r_sel_reject;
  assign change_valid  = r_change_valid;
  assign change_amount = r_change_amount;
  assign fault         = r_fault;
  assign busy          = r_busy;

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Top-level vend sequencer for the vending machine. It accumulates coin credit, validates a product selection against a per-slot price table, and drives the dispenser with a dispense request plus payment confirmation. It waits for the motor acknowledge, then returns change or a refund. It sits between the coin acceptor / keypad front end and the product dispenser.

Parameters:
N_SLOTS, 8, number of product slots (selection index width = clog2(N_SLOTS), min 1)
CREDIT_W, 8, width of credit, price and change values (cents units)
MAX_CREDIT, 200, credit ceiling; coins that would exceed it are rejected
PRICES, {8{8'd50}}, packed N_SLOTS*CREDIT_W price table, slot k at bits [k*CREDIT_W +: CREDIT_W]
DISP_TIMEOUT, 255, max cycles to wait for disp_done before faulting

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
coin_valid  in  1  one-cycle strobe, coin inserted
coin_value  in  CREDIT_W  value of inserted coin
sel_valid  in  1  one-cycle strobe, product selected
sel_id  in  clog2(N_SLOTS)  selected slot
cancel  in  1  one-cycle strobe, refund request
disp_done  in  1  dispenser motor completion pulse
dispense_req  out  1  request to dispenser, held in VEND
payment_ok  out  1  payment confirmed, held in VEND
slot  out  clog2(N_SLOTS)  slot being vended, valid in VEND
credit  out  CREDIT_W  current accumulated credit
coin_reject  out  1  one-cycle pulse, coin returned
sel_reject  out  1  one-cycle pulse, selection refused
change_valid  out  1  one-cycle pulse, change_amount valid
change_amount  out  CREDIT_W  change/refund value
fault  out  1  sticky until next accepted coin or rst; set on dispense timeout
busy  out  1  high in VEND and CHANGE

Behaviour:
- Reset: all outputs 0, credit 0, state IDLE, timeout counter 0.
- States: IDLE (credit=0), CREDIT, VEND, CHANGE. All outputs are registered.
- IDLE/CREDIT, coin_valid:
  - credit+coin_value <= MAX_CREDIT (compare at CREDIT_W+1 bits): credit += coin_value next cycle; go to CREDIT; clear fault.
  - Otherwise: coin_reject pulses; credit unchanged.
- CREDIT, sel_valid:
  - sel_id >= N_SLOTS or credit < PRICES[sel_id]: sel_reject pulses; state unchanged.
  - Otherwise: latch slot and price; enter VEND next cycle. dispense_req and payment_ok go high 1 cycle after the accepted sel_valid.
- IDLE, sel_valid: sel_reject pulses.
- CREDIT, cancel: change_valid=1 and change_amount=credit for one cycle; credit->0; go to IDLE.
- IDLE, cancel: ignored.
- Same-cycle priority: cancel > sel_valid > coin_valid.
  - A coin_valid that loses to cancel or an accepted sel_valid gets coin_reject.
  - A sel_valid that loses to cancel is dropped silently.
- VEND:
  - dispense_req=payment_ok=1; timeout counter increments.
  - disp_done: deassert both next cycle; credit -= price; go to CHANGE.
  - Counter reaches DISP_TIMEOUT without disp_done: deassert; fault=1; price not charged; go to CHANGE.
  - coin_valid in VEND or CHANGE: coin_reject. sel_valid and cancel ignored.
- CHANGE (one cycle):
  - credit != 0: change_valid pulses with change_amount=credit.
  - credit == 0: no pulse.
  - credit->0; go to IDLE.
- Exact-price vend: no change pulse.
- Total latency, sel accepted to IDLE: 1 + (cycles to disp_done) + 1 + 1.
- change_amount holds its last value when change_valid=0.
- rst mid-VEND: immediate return to reset state; credit is lost by design. Front end must not assert rst with credit pending.

Optional Feature:
VEND_STOCK_EN
- Defined:
  - Per-slot stock counters (8 bits each), loaded on rst from parameter STOCK_INIT (default 8'd10 per slot).
  - Selecting a slot with stock 0 gives sel_reject.
  - Successful disp_done decrements that slot's stock; a timeout does not decrement.
  - Adds output sold_out[N_SLOTS-1:0], one bit per slot, high when stock==0.
- Undefined: no counters, no sold_out port; stock treated as unlimited.

Test Plan:
- Coins 25,25,10 then sel_id=2 (price 50) -> credit 60; dispense_req=payment_ok=1 one cycle after sel; disp_done after 5 cycles -> change_valid pulse, change_amount=10, credit 0, IDLE.
- Credit 40, select price-50 slot -> sel_reject pulse, credit stays 40; cancel -> change_valid, change_amount=40.
- Credit 190, coin 25 (MAX_CREDIT 200) -> coin_reject, credit 190; coin 10 -> credit 200.
- Credit 50, vend, no disp_done -> after 255 cycles dispense_req=0, fault=1, change_amount=50 refunded.
- Same-cycle cancel+sel_valid+coin_valid with credit 50 -> refund 50, coin_reject pulse, no vend.
- VEND_STOCK_EN, STOCK_INIT=1: vend slot 0 twice with sufficient credit -> first dispenses, sold_out[0]=1, second gives sel_reject.
